// File: rtl/seq_pkg.sv
// Shared types and defaults for the 01[0*]1 detector streaming controller.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2,
        CLEAR  = 2'd3
    } ctrl_state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register feeding the detector's serial input.
module seq_piso
    import seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q_msb
);

    logic [WORD_W-1:0] shreg_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= d;
        end else if (shift) begin
            shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
        end
    end

    assign q_msb = shreg_q[WORD_W-1];

endmodule

// File: rtl/seq_stream_ctrl.sv
// Streams parallel words bit-serially into the sequence detector and reports
// per-word and per-stream detection counts over a valid/ready handshake.
module seq_stream_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_last,
    output logic              det_ena,
    output logic              det_bit,
    output logic              det_clr,
    input  logic              det_z,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [CNT_W-1:0]  res_total,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W);

    if (WORD_W < 2 || WORD_W > 32) begin : g_word_w_chk
        $error("seq_stream_ctrl: WORD_W must lie in 2..32");
    end
    if (CNT_W < $clog2(WORD_W + 1)) begin : g_cnt_w_chk
        $error("seq_stream_ctrl: CNT_W too narrow to count every bit of a word");
    end

    ctrl_state_t      state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] stream_cnt_q, stream_cnt_d;
    logic             last_q, last_d;
    logic             load, shift, q_msb;

    seq_piso #(.WORD_W(WORD_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     (in_word),
        .q_msb (q_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            word_cnt_q   <= '0;
            stream_cnt_q <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            word_cnt_q   <= word_cnt_d;
            stream_cnt_q <= stream_cnt_d;
            last_q       <= last_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        word_cnt_d   = word_cnt_q;
        stream_cnt_d = stream_cnt_q;
        last_d       = last_q;
        in_ready     = 1'b0;
        det_ena      = 1'b0;
        det_bit      = 1'b0;
        det_clr      = 1'b0;
        res_valid    = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    last_d     = in_last;
                    bit_idx_d  = IDX_W'(WORD_W - 1);
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                det_ena = 1'b1;
                det_bit = q_msb;
                shift   = 1'b1;
                // det_z is the detector's Mealy response to the bit driven this very cycle.
                if (det_z) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (stream_cnt_q != {CNT_W{1'b1}}) begin
                        stream_cnt_d = stream_cnt_q + CNT_W'(1);
                    end
                end
                if (bit_idx_q == '0) begin
                    state_d = REPORT;
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = last_q ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                det_clr      = 1'b1;
                stream_cnt_d = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset holds the detector in reset alongside the controller and blocks any handshake.
        if (rst) begin
            in_ready  = 1'b0;
            det_ena   = 1'b0;
            det_bit   = 1'b0;
            res_valid = 1'b0;
            load      = 1'b0;
            shift     = 1'b0;
            det_clr   = 1'b1;
        end
    end

    assign res_count = word_cnt_q;
    assign res_total = stream_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed and randomized bench for seq_stream_ctrl with a stub/behavioural detector on det_z.
module tb_seq_stream_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_last;
    logic              det_ena;
    logic              det_bit;
    logic              det_clr;
    logic              det_z;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic [CNT_W-1:0]  res_total;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int exp_total = 0;

    seq_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .det_ena   (det_ena),
        .det_bit   (det_bit),
        .det_clr   (det_clr),
        .det_z     (det_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_count (res_count),
        .res_total (res_total),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Detector stand-in: either a per-word mask of enabled-cycle indices, or a
    // behavioural 01[0*]1 matcher over the bit history since the last clear.
    int          en_idx   = 0;
    logic [7:0]  z_mask   = '0;
    bit          z_mode   = 1'b0;
    logic [63:0] hist     = '0;
    int          hist_len = 0;

    always @(posedge clk) begin
        if (det_ena) en_idx <= en_idx + 1;
        else         en_idx <= 0;
        if (det_clr) begin
            hist     <= '0;
            hist_len <= 0;
        end else if (det_ena) begin
            hist     <= {hist[62:0], det_bit};
            hist_len <= (hist_len < 62) ? hist_len + 1 : hist_len;
        end
    end

    // hist[0] is the newest past bit; a 1 now completes 0 1 0* 1.
    function automatic bit det_match(input logic [63:0] h, input int len);
        int j;
        j = 0;
        while (j < len && j < 63 && h[j] == 1'b0) j++;
        return (j + 1 < len) && h[j] && !h[j+1];
    endfunction

    always_comb begin
        det_z = 1'b0;
        if (det_ena) begin
            if (z_mode) det_z = det_bit && det_match(hist, hist_len);
            else        det_z = (en_idx < 8) ? z_mask[en_idx] : 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one word, checks serialization, latency, report contents and the
    // post-report state. Optionally presents the next word while REPORT is held.
    task automatic send_word(input logic [7:0] w, input bit last, input logic [7:0] mask,
                             input int exp_cnt, input int hold,
                             input bit stall, input logic [7:0] nxt_w, input bit nxt_last);
        int         waited;
        logic [7:0] got;
        z_mask   = mask;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 8'($urandom);
        in_last  = 1'($urandom);
        got      = '0;
        for (int k = 0; k < WORD_W; k++) begin
            check("det_ena_shift", det_ena, 1);
            check("res_valid_shift", res_valid, 0);
            check("det_clr_shift", det_clr, 0);
            check("in_ready_shift", in_ready, 0);
            got = {got[6:0], det_bit};
            @(negedge clk);
        end
        check("det_bit_seq", got, w);
        check("res_valid_latency", res_valid, 1);
        exp_total = (exp_total + exp_cnt > SAT) ? SAT : exp_total + exp_cnt;
        check("res_count", res_count, exp_cnt);
        check("res_total", res_total, exp_total);
        if (stall) begin
            in_valid = 1'b1;
            in_word  = nxt_w;
            in_last  = nxt_last;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_count", res_count, exp_cnt);
            check("hold_res_total", res_total, exp_total);
            check("hold_det_ena", det_ena, 0);
            check("hold_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (last) begin
            check("clear_det_clr", det_clr, 1);
            check("clear_busy", busy, 1);
            check("clear_res_valid", res_valid, 0);
            check("clear_in_ready", in_ready, 0);
            exp_total = 0;
            @(negedge clk);
            check("after_clear_det_clr", det_clr, 0);
        end
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_res_valid", res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w, m;
        bit         l;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_det_clr", det_clr, 1);
        check("rst_det_ena", det_ena, 0);
        check("rst_det_bit", det_bit, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_total", res_total, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_det_clr", det_clr, 0);

        // det_z on the 3rd and 7th enabled cycles.
        send_word(8'hA5, 1'b0, 8'b0100_0100, 2, 0, 1'b0, 8'h00, 1'b0);
        // Single hit, last word of the stream.
        send_word(8'h5A, 1'b1, 8'b0000_0001, 1, 0, 1'b0, 8'h00, 1'b0);
        // REPORT held for 5 cycles while the next word waits on in_valid.
        send_word(8'h96, 1'b0, 8'b0001_0000, 1, 5, 1'b1, 8'h3C, 1'b1);
        send_word(8'h3C, 1'b1, 8'b0000_0000, 0, 0, 1'b0, 8'h00, 1'b0);

        // Every enabled cycle hits: stream total saturates.
        send_word(8'hFF, 1'b0, 8'hFF, 8, 0, 1'b0, 8'h00, 1'b0);
        check("sat_total_1", res_total, 8);
        send_word(8'h00, 1'b0, 8'hFF, 8, 1, 1'b0, 8'h00, 1'b0);
        check("sat_total_2", res_total, 15);
        send_word(8'hC3, 1'b1, 8'hFF, 8, 0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 12; i++) begin
            w = 8'($urandom);
            m = 8'($urandom);
            l = ($urandom_range(0, 3) == 0);
            send_word(w, l, m, $countones(m), $urandom_range(0, 3), 1'b0, 8'h00, 1'b0);
        end

        // Reset during the 4th SHIFT cycle discards the word.
        in_valid = 1'b1;
        in_word  = 8'($urandom);
        in_last  = 1'b0;
        z_mask   = 8'hFF;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        check("rst_test_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_test_in_shift", det_ena, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_det_ena", det_ena, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_det_clr", det_clr, 1);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_res_total", res_total, 0);
        rst = 1'b0;
        exp_total = 0;
        @(negedge clk);
        check("after_midrst_det_clr", det_clr, 0);
        for (int k = 0; k < 12; k++) begin
            check("after_midrst_no_result", res_valid, 0);
            check("after_midrst_idle", busy, 0);
            @(negedge clk);
        end

        // Behavioural detector: 0 1 | 0 0 1 spans the word boundary.
        z_mode = 1'b1;
        send_word(8'b0000_0001, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 1'b0);
        send_word(8'b0010_0000, 1'b1, 8'h00, 1, 0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Streaming controller for the 01[0*]1 sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto the detector's serial input, one bit per `det_ena` cycle.
- Samples the detector's Mealy `z` on each enabled cycle, counts detections per word and per stream, and returns the results over a second valid/ready handshake.
- Clears the detector between streams. Sits between the host/test interface and the detector instance.

Parameters:
- WORD_W, 8, bits per input word; legal range 2..32.
- CNT_W, 8, width of the per-word and per-stream detection counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_word  in  WORD_W  word to serialize, MSB sent first
- in_last  in  1  word is last of a stream; detector is cleared after its report
- det_ena  out  1  detector enable; one serial bit is consumed per high cycle
- det_bit  out  1  serial bit to the detector input
- det_clr  out  1  detector synchronous reset
- det_z  in  1  detector Mealy output for the current bit
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_count  out  CNT_W  detections within the reported word
- res_total  out  CNT_W  detections in the stream so far, this word included, saturating
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - state=IDLE; in_ready=0 during rst, 1 from the first cycle after.
  - det_ena=0, det_bit=0, res_valid=0; res_count, res_total, word and stream counters all 0.
  - det_clr=1 while rst is high, so the detector resets in the same cycles.
- States are IDLE, SHIFT, REPORT, CLEAR; 2-bit encoding in seq_pkg.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_word into the shift register and in_last into last_q; load bit_idx=WORD_W-1; clear word_cnt; go to SHIFT.
- SHIFT:
  - det_ena=1 every cycle; det_bit=shreg[MSB]; shreg shifts left by one per cycle.
  - det_z is sampled in the same cycle as its det_bit (combinational Mealy path).
  - When det_z=1: word_cnt increments, and stream_cnt increments with saturation at 2^CNT_W-1. word_cnt cannot overflow if CNT_W >= clog2(WORD_W+1); assert this at elaboration.
  - After exactly WORD_W enabled cycles (bit_idx==0), go to REPORT.
- REPORT:
  - det_ena=0 and the detector holds its state; res_valid=1.
  - res_count=word_cnt and res_total=stream_cnt, both held stable until res_ready.
  - On res_valid&res_ready: if last_q go to CLEAR, else go to IDLE.
- CLEAR:
  - det_clr=1 for exactly one cycle; stream_cnt<=0; go to IDLE.
  - Detector state is preserved across words inside a stream, so patterns spanning a word boundary are counted.
- Latency:
  - From input acceptance to res_valid: WORD_W+1 cycles.
  - Minimum word-to-word period: WORD_W+2 cycles, or WORD_W+3 on a last word.
- in_ready=0 in SHIFT, REPORT and CLEAR. Words presented in those states are stalled, not dropped.
- in_word and in_last are don't-care while in_valid=0. The controller must never advance without a handshake.
- res_ready held high continuously gives a one-cycle REPORT. res_valid must not drop before acceptance.
- Reset mid-operation in any state: immediate return to reset values. The in-flight word is discarded with no result.
- A stream of a single word with in_last=1 is legal.

Decomposition:
- Package seq_pkg holds:
  - enum ctrl_state_t {IDLE, SHIFT, REPORT, CLEAR};
  - localparam DEF_WORD_W=8;
  - localparam DEF_CNT_W=8.
- Sub-module seq_piso: parallel-load, MSB-first shift register.
  - Ports: clk, rst, load, shift, d[WORD_W], q_msb.
- FSM, counters and handshakes stay in seq_stream_ctrl.

Test Plan:
- Bench uses a stub for det_z, asserting it on the 3rd and 7th enabled cycles. Send word 8'hA5 with in_last=0 -> det_bit sequence 1,0,1,0,0,1,0,1; res_valid exactly 9 cycles after acceptance; res_count=2; res_total=2; det_clr stays 0.
- Next word with det_z asserted on 1 cycle, in_last=1 -> res_count=1, res_total=3. On acceptance, det_clr pulses for exactly 1 cycle; the next word's res_total starts from 0.
- Hold res_ready=0 for 5 cycles in REPORT -> res_valid, res_count and res_total stable; det_ena=0; in_ready=0; an in_valid presented meanwhile is stalled, then accepted after IDLE.
- det_z asserted on every enabled cycle with CNT_W=4 over 3 words -> res_count=8 for each word; res_total=8, then 15, then 15 (saturated).
- Assert rst during the 4th SHIFT cycle -> next cycle det_ena=0, res_valid=0, busy=0, det_clr=1 during rst; no result emitted for the in-flight word.
- Integration with the real detector, stream bits 0,1,0,0,1 across two WORD_W=4 words (0100, 1xxx) -> one detection counted in the second word's res_count, confirming state persists across the word boundary.
